// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers.
// Contents:
//   - per-boundary LANES/DATA_W defaults for IF_ID, ID_EXE, EXE_MEM and MEM_WB
//   - default stall counter width
//   - skid entry state type
//   - lane_lo(): low bit index of a lane slice inside a packed lane bus
package pipe_stage_buf_pkg;

   localparam int unsigned IF_ID_LANES    = 2;
   localparam int unsigned IF_ID_DATA_W   = 64;
   localparam int unsigned ID_EXE_LANES   = 2;
   localparam int unsigned ID_EXE_DATA_W  = 150;
   localparam int unsigned EXE_MEM_LANES  = 2;
   localparam int unsigned EXE_MEM_DATA_W = 71;
   localparam int unsigned MEM_WB_LANES   = 2;
   localparam int unsigned MEM_WB_DATA_W  = 70;

   localparam int unsigned PSB_CNT_W = 32;

   typedef enum logic {
      SkidEmpty,
      SkidFull
   } skid_state_e;

   // Lane i of a packed bus lives at [lane_lo(i, w) +: w].
   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
      return lane * w;
   endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One lane of a pipeline buffer entry: a valid bit plus its payload.
// Ports:
//   clk, rst_n   clock, asynchronous active-high reset
//   flush        clear the valid bit (highest priority)
//   load         replace the valid bit with valid_in
//   kill         clear the valid bit when not loading
//   valid_in     incoming valid
//   data_in      incoming payload, written only on load with valid_in set
//   valid, data  registered lane contents
module pipe_lane_reg #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load,
   input  logic              kill,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   // A load beats a kill: the kill targets the entry's old occupant only.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= valid_in;
      end else if (kill) begin
         valid_q <= 1'b0;
      end
   end

   // Invalid lanes keep their previous payload.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         data_q <= '0;
      end else if (load && valid_in) begin
         data_q <= data_in;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline buffer carrying LANES parallel lanes.
// Ports:
//   clk, rst_n        clock, asynchronous active-high reset
//   flush_i           kill every held and incoming lane
//   kill_lane_i       per-lane kill of the held main entry
//   pre_valid_i       upstream lane valids
//   pre_bus_i         upstream payload, lane i at [i*DATA_W +: DATA_W]
//   pre_allowin_o     stage accepts upstream data this cycle
//   now_ready_go_i    this stage's work is finished
//   next_allowin_i    downstream allowin
//   now_valid_o       main-entry lane valids
//   now_bus_o         main-entry payload
//   to_next_valid_o   valids offered downstream
//   stall_cnt_o       saturating count of cycles held without advancing
// SKID=0 gives a single register stage with combinational allowin; SKID=1 adds
// a skid entry so that pre_allowin_o comes straight from a register.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned LANES  = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SKID   = 0,
   parameter int unsigned CNT_W  = PSB_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic [LANES-1:0]        kill_lane_i,
   input  logic [LANES-1:0]        pre_valid_i,
   input  logic [LANES*DATA_W-1:0] pre_bus_i,
   output logic                    pre_allowin_o,
   input  logic                    now_ready_go_i,
   input  logic                    next_allowin_i,
   output logic [LANES-1:0]        now_valid_o,
   output logic [LANES*DATA_W-1:0] now_bus_o,
   output logic [LANES-1:0]        to_next_valid_o,
   output logic [CNT_W-1:0]        stall_cnt_o
);

   logic [LANES-1:0]        main_valid;
   logic [LANES-1:0]        main_vin;
   logic [LANES*DATA_W-1:0] main_bus;
   logic [LANES*DATA_W-1:0] main_din;
   logic                    main_load;
   logic                    any_v;
   logic                    drain;
   logic [CNT_W-1:0]        stall_cnt_q;
   logic [CNT_W-1:0]        stall_cnt_d;

   assign any_v = |main_valid;
   assign drain = any_v & now_ready_go_i & next_allowin_i;

   if (SKID == 0) begin : g_direct
      logic accept;

      assign pre_allowin_o = ~any_v | drain;
      assign accept        = (|pre_valid_i) & pre_allowin_o & ~flush_i;

      // Drain without accept loads all-zero valids, emptying the entry.
      always_comb begin
         main_load = accept | drain;
         main_vin  = accept ? pre_valid_i : '0;
         main_din  = pre_bus_i;
      end
   end else begin : g_skid
      skid_state_e             state_q;
      skid_state_e             state_d;
      logic [LANES-1:0]        skid_valid;
      logic [LANES-1:0]        skid_vin;
      logic [LANES*DATA_W-1:0] skid_bus;
      logic                    skid_load;
      logic                    main_free;
      logic                    move;
      logic                    accept;
      logic                    to_main;
      logic                    to_skid;

      assign main_free     = ~any_v | drain;
      // A full skid also refills main when main was emptied by kills.
      assign move          = (state_q == SkidFull) & main_free;
      assign accept        = (|pre_valid_i) & (state_q == SkidEmpty) & ~flush_i;
      assign to_main       = accept & main_free;
      assign to_skid       = accept & ~main_free;
      assign pre_allowin_o = (state_q == SkidEmpty);

      always_ff @(posedge clk or posedge rst_n) begin
         if (rst_n) begin
            state_q <= SkidEmpty;
         end else begin
            state_q <= state_d;
         end
      end

      always_comb begin
         state_d   = state_q;
         main_load = move | to_main | drain;
         main_vin  = '0;
         main_din  = pre_bus_i;
         skid_load = to_skid | move;
         skid_vin  = to_skid ? pre_valid_i : '0;
         if (flush_i) begin
            state_d = SkidEmpty;
         end else if (to_skid) begin
            state_d = SkidFull;
         end else if (move) begin
            state_d = SkidEmpty;
         end
         if (move) begin
            main_vin = skid_valid;
            main_din = skid_bus;
         end else if (to_main) begin
            main_vin = pre_valid_i;
         end
      end

      for (genvar i = 0; i < LANES; i++) begin : g_skid_lane
         pipe_lane_reg #(
            .DATA_W (DATA_W)
         ) u_skid_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush_i),
            .load     (skid_load),
            .kill     (1'b0),
            .valid_in (skid_vin[i]),
            .data_in  (pre_bus_i[lane_lo(i, DATA_W) +: DATA_W]),
            .valid    (skid_valid[i]),
            .data     (skid_bus[lane_lo(i, DATA_W) +: DATA_W])
         );
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_main_lane
      pipe_lane_reg #(
         .DATA_W (DATA_W)
      ) u_main_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush_i),
         .load     (main_load),
         .kill     (kill_lane_i[i]),
         .valid_in (main_vin[i]),
         .data_in  (main_din[lane_lo(i, DATA_W) +: DATA_W]),
         .valid    (main_valid[i]),
         .data     (main_bus[lane_lo(i, DATA_W) +: DATA_W])
      );
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (any_v && !drain && !flush_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign now_valid_o     = main_valid;
   assign now_bus_o       = main_bus;
   assign to_next_valid_o = main_valid & {LANES{now_ready_go_i}};
   assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline buffer for the multi-issue core: the successor to the fixed two-line stage registers between IF/ID/EXE/MEM/WB. It carries LANES parallel instruction lanes with per-lane valid, generates its own allowin from ready_go and downstream allowin, supports whole-stage and per-lane kill, and can optionally insert a 2-entry skid buffer so that upstream allowin comes from a register and not from a combinational path. A saturating stall counter feeds the performance counters.

## Interface
- LANES, 2, number of issue lanes (1..4)
- DATA_W, 32, payload bits per lane
- SKID, 0, 0 = single register stage; 1 = main + skid entry, registered pre_allowin_o
- CNT_W, 32, stall counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1)
- flush_i  in  1  exception flush; kills every held and incoming lane
- kill_lane_i  in  LANES  per-lane kill of currently held main-entry lanes
- pre_valid_i  in  LANES  upstream lane valids
- pre_bus_i  in  LANES*DATA_W  upstream payload, lane i at [i*DATA_W +: DATA_W]
- pre_allowin_o  out  1  this stage accepts upstream data this cycle
- now_ready_go_i  in  1  this stage's combinational work is finished
- next_allowin_i  in  1  downstream allowin
- now_valid_o  out  LANES  main-entry lane valids
- now_bus_o  out  LANES*DATA_W  main-entry payload
- to_next_valid_o  out  LANES  now_valid_o & {LANES{now_ready_go_i}}
- stall_cnt_o  out  CNT_W  cycles with any lane valid and not advancing

## Operation
- Reset: now_valid_o = 0, skid valids = 0, now_bus_o = 0, skid data = 0, stall_cnt_o = 0; pre_allowin_o = 1.
- any_v = |now_valid_o; drain = any_v & now_ready_go_i & next_allowin_i.
- SKID=0: pre_allowin_o = ~any_v | drain (combinational). Accept = (|pre_valid_i) & pre_allowin_o. On accept the main entry loads all lane valids. Per lane, data loads only when pre_valid_i[i] = 1; payload of invalid lanes holds its previous value. On drain without accept, valids go to 0.
- SKID=1: pre_allowin_o = ~skid_full (register). Accept while the main entry is empty or draining loads main directly. Accept while main is held and not draining loads the skid entry, and skid_full is set. While skid_full, drain moves skid to main and clears skid_full. Order is strictly preserved.
- kill_lane_i[i]: clears now_valid_o[i] at the next edge. Data is kept. Skid is unaffected. If the same lane loads in that cycle, the load wins, because the kill applies to the old occupant only.
- flush_i: highest priority. It clears all main and skid valids and clears skid_full, and any concurrent accept is discarded. Data registers are not required to clear.
- stall_cnt_o increments when any_v & ~drain & ~flush_i, and saturates at all-ones.

## Timing
- Latency from accept to now_valid_o is 1 cycle (SKID=0), and 1 cycle when main is free (SKID=1). A skid-held item reaches main on the first drain edge.
- SKID=1: pre_allowin_o falls in the cycle after the skid entry fills. It rises in the cycle after the skid entry moves to main.
- Simultaneous drain and accept (SKID=0): the new data replaces the old in the same edge with no bubble.
- Asynchronous reset mid-transfer: all valids drop immediately. Accepts in flight are lost.
- to_next_valid_o is combinational from the registered valid and now_ready_go_i.

## Structure
- Shared package/header: lane-slice macro, LANES/DATA_W defaults per stage (IF_ID, ID_EXE, EXE_MEM, MEM_WB), and CNT_W.
- One sub-module, pipe_lane_reg: a per-lane valid+data register with load/kill/flush. It is instantiated LANES times for main, and again for skid when SKID=1.
- Existing stage boundaries are replaced by instances of this block, with SKID=0 to keep current timing.

## Test plan
- SKID=0, LANES=2: pre_valid=2'b11, bus={B,A}, next_allowin=1, ready_go=1 -> next cycle now_valid=2'b11, now_bus={B,A}; to_next_valid=2'b11.
- pre_valid=2'b01 with lane1 holding 0xDEAD from before -> lane1 data stays 0xDEAD, now_valid=2'b01.
- SKID=1: next_allowin=0, send A then B -> A in main, B in skid, pre_allowin_o=0 one cycle later. Raise next_allowin -> A, then B, each appear on successive cycles in order.
- flush_i with accept in the same cycle -> next cycle all valids 0, skid empty, pre_allowin_o=1.
- kill_lane_i=2'b10 on held 2'b11 -> now_valid=2'b01. Same kill while lane1 reloads -> lane1 valid stays 1 with the new data.
- Hold any_v with next_allowin=0 for 5 cycles from reset -> stall_cnt_o=5. With CNT_W=3 held for 10 cycles -> stall_cnt_o=7.
